// File: rtl/otf_qconv.sv
// On-the-fly quotient converter for a radix-4 SRT divider: folds one one-hot digit
// (-3..+3) per cycle into the Q/QM pair, then picks Q or QM from the final remainder sign.
module otf_qconv #(
  parameter int unsigned NDIG = 14
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 dig_vld,
  input  logic                 mul_n3,
  input  logic                 mul_n2,
  input  logic                 mul_n1,
  input  logic                 mul_0,
  input  logic                 mul_1,
  input  logic                 mul_2,
  input  logic                 mul_3,
  input  logic                 rem_vld,
  input  logic                 rem_neg,
  output logic [2*NDIG-1:0]    quo,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned QW   = 2 * NDIG;
  localparam int unsigned CntW = $clog2(NDIG + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StConv = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [QW-1:0]   q_q, q_d;
  logic [QW-1:0]   qm_q, qm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [6:0]      mul_v;
  logic            dig_ok, dig_pos, dig_neg;
  logic [1:0]      q_app, qm_app;
  logic [QW-1:0]   q_base, qm_base;

  assign mul_v   = {mul_3, mul_2, mul_1, mul_0, mul_n1, mul_n2, mul_n3};
  assign dig_ok  = (mul_v != 7'd0) && ((mul_v & (mul_v - 7'd1)) == 7'd0);
  assign dig_pos = dig_ok && (mul_1 || mul_2 || mul_3);
  assign dig_neg = dig_ok && (mul_n1 || mul_n2 || mul_n3);

  // Appended pair is q (mod 4) for Q; QM always takes that value minus one (mod 4).
  always_comb begin
    q_app = 2'd0;
    if (dig_pos) begin
      q_app = mul_3 ? 2'd3 : (mul_2 ? 2'd2 : 2'd1);
    end else if (dig_neg) begin
      q_app = mul_n1 ? 2'd3 : (mul_n2 ? 2'd2 : 2'd1);
    end
    qm_app  = q_app - 2'd1;
    q_base  = dig_neg ? qm_q : q_q;
    qm_base = dig_pos ? q_q : qm_q;
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = StConv;
      q_d     = '0;
      qm_d    = '1;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        StConv: begin
          if (dig_vld) begin
            q_d   = {q_base[QW-3:0], q_app};
            qm_d  = {qm_base[QW-3:0], qm_app};
            cnt_d = cnt_q + CntW'(1);
            if (!dig_ok) err_d = 1'b1;
            if (cnt_q == CntW'(NDIG - 1)) state_d = StFin;
          end
        end
        StFin: begin
          if (rem_vld) begin
            quo_d   = rem_neg ? qm_q : q_q;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
        StIdle:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      qm_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign quo  = quo_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_otf_qconv.sv
// Bench for otf_qconv: directed vector table plus random digit streams checked against
// an arithmetic model (quotient = sum of q_i * 4^(NDIG-1-i), minus one if remainder < 0).
module tb_otf_qconv;
  localparam int NDIG = 14;
  localparam int QW   = 2 * NDIG;

  typedef logic [6:0] dvec_t [NDIG];  // bit0 = mul_n3 ... bit6 = mul_3
  typedef struct {
    dvec_t         m;
    bit            neg;
    logic [QW-1:0] q;
    bit            e;
  } vec_t;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0, dig_vld = 1'b0, rem_vld = 1'b0, rem_neg = 1'b0;
  logic [6:0]    mv = 7'd0;
  logic [QW-1:0] quo;
  logic          busy, done, err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  otf_qconv #(.NDIG(NDIG)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .dig_vld(dig_vld),
    .mul_n3(mv[0]), .mul_n2(mv[1]), .mul_n1(mv[2]), .mul_0(mv[3]),
    .mul_1(mv[4]), .mul_2(mv[5]), .mul_3(mv[6]),
    .rem_vld(rem_vld), .rem_neg(rem_neg), .quo(quo), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] mk(input int q);
    logic [6:0] one = 7'd1;
    return one << (q + 3);
  endfunction

  function automatic bit is_onehot(input logic [6:0] m);
    return $countones(m) == 1;
  endfunction

  function automatic logic [QW-1:0] model_quo(input dvec_t m, input bit neg);
    logic [QW-1:0] acc = '0;
    int v;
    for (int i = 0; i < NDIG; i++) begin
      v = 0;
      for (int b = 0; b < 7; b++) if (is_onehot(m[i]) && m[i][b]) v = b - 3;
      acc = acc * 4 + QW'(v);
    end
    return neg ? acc - 1 : acc;
  endfunction

  function automatic bit model_err(input dvec_t m);
    for (int i = 0; i < NDIG; i++) if (!is_onehot(m[i])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic send_digits(input dvec_t m, input int n, input int maxgap, input bit noise);
    for (int i = 0; i < n; i++) begin
      repeat ((maxgap > 0) ? $urandom_range(0, maxgap) : 0) begin
        dig_vld = 1'b0; rem_vld = noise; rem_neg = 1'b1; mv = 7'($urandom);
        tick();
      end
      rem_vld = 1'b0; dig_vld = 1'b1; mv = m[i];
      tick();
    end
    dig_vld = 1'b0; mv = 7'd0;
  endtask

  task automatic run(input dvec_t m, input bit neg, input int maxgap, input bit noise,
                     input logic [QW-1:0] exp_q, input bit exp_e, input string tag);
    int d0;
    start = 1'b1; tick(); start = 1'b0;
    d0 = done_cnt;
    send_digits(m, NDIG, maxgap, noise);
    chk({tag, " fin_busy"}, busy, 1);
    chk({tag, " no_early_done"}, done_cnt, d0);
    rem_vld = 1'b1; rem_neg = neg; tick(); rem_vld = 1'b0; rem_neg = 1'b0;
    chk({tag, " done"}, done, 1);
    chk({tag, " quo"}, quo, exp_q);
    chk({tag, " err"}, err, exp_e);
    tick();
    chk({tag, " done_once"}, done_cnt, d0 + 1);
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " quo_hold"}, quo, exp_q);
  endtask

  vec_t  tbl[6];
  dvec_t dv;
  logic [QW-1:0] qsave;
  int    d1;

  initial begin
    for (int i = 0; i < NDIG; i++) begin
      tbl[0].m[i] = mk(0);
      tbl[1].m[i] = mk(3);
      tbl[2].m[i] = mk(3);
      tbl[3].m[i] = mk(0);
      tbl[4].m[i] = mk(0);
      tbl[5].m[i] = mk(0);
    end
    tbl[3].m[0] = mk(1); tbl[3].m[1] = mk(-1);
    tbl[4].m[0] = mk(1); tbl[4].m[1] = mk(-1);
    tbl[5].m[0] = 7'b0110000;  // mul_1 and mul_2 together
    tbl[0].neg = 0; tbl[0].q = 28'h0000000; tbl[0].e = 0;
    tbl[1].neg = 0; tbl[1].q = 28'hFFFFFFF; tbl[1].e = 0;
    tbl[2].neg = 1; tbl[2].q = 28'hFFFFFFE; tbl[2].e = 0;
    tbl[3].neg = 0; tbl[3].q = 28'h3000000; tbl[3].e = 0;
    tbl[4].neg = 1; tbl[4].q = 28'h2FFFFFF; tbl[4].e = 0;
    tbl[5].neg = 0; tbl[5].q = 28'h0000000; tbl[5].e = 1;

    #12;
    chk("rst_quo", quo, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0);
    n_rst = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) run(tbl[k].m, tbl[k].neg, 0, 0, tbl[k].q, tbl[k].e, $sformatf("vec%0d", k));

    // err stays set after done until the next start clears it
    chk("err_sticky", err, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("err_clear", err, 0);

    // IDLE ignores rem_vld
    send_digits(tbl[0].m, NDIG, 0, 0);
    rem_vld = 1'b1; tick(); rem_vld = 1'b0; tick();
    d1 = done_cnt;
    rem_vld = 1'b1; dig_vld = 1'b1; tick(); rem_vld = 1'b0; dig_vld = 1'b0; tick();
    chk("idle_ignore", done_cnt, d1);

    // abort after 7 digits, then gapped +2 stream with rem_vld noise during CONV
    for (int i = 0; i < NDIG; i++) dv[i] = mk(2);
    start = 1'b1; tick(); start = 1'b0;
    send_digits(tbl[1].m, 7, 0, 0);
    run(dv, 0, 3, 1, 28'hAAAAAAA, 0, "restart");

    // reset while in FIN
    for (int i = 0; i < NDIG; i++) dv[i] = mk(-1);
    start = 1'b1; tick(); start = 1'b0;
    send_digits(dv, NDIG, 0, 0);
    d1 = done_cnt;
    #2 n_rst = 1'b0; #1;
    chk("arst_quo", quo, 0); chk("arst_busy", busy, 0);
    chk("arst_done", done, 0); chk("arst_err", err, 0);
    tick(); n_rst = 1'b1; tick();
    chk("arst_no_done", done_cnt, d1);

    // start beats rem_vld in FIN
    run(tbl[3].m, 0, 0, 0, 28'h3000000, 0, "pre");
    qsave = quo;
    start = 1'b1; tick(); start = 1'b0;
    send_digits(dv, NDIG, 0, 0);
    d1 = done_cnt;
    start = 1'b1; rem_vld = 1'b1; tick(); start = 1'b0; rem_vld = 1'b0;
    chk("race_done", done, 0); chk("race_quo", quo, qsave); chk("race_busy", busy, 1);
    tick();
    chk("race_no_done", done_cnt, d1);

    // random streams against the arithmetic model
    for (int r = 0; r < 10; r++) begin
      bit neg;
      for (int i = 0; i < NDIG; i++)
        dv[i] = ($urandom_range(0, 15) == 0) ? 7'($urandom) : mk(int'($urandom_range(0, 6)) - 3);
      neg = 1'($urandom);
      run(dv, neg, 2, r[0], model_quo(dv, neg), model_err(dv), $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
